// File: rtl/cu_microsequencer.sv
// Microprogram sequencer: holds the control address register (CAR) and computes the
// next control-memory address from the sequencing op, a runtime-loadable opcode
// dispatch map, a conditional branch unit and a micro-subroutine return stack.
// Step-execution wait and halt/resume are explicit sequencer states.
module cu_microsequencer #(
    parameter int unsigned ADDR_W        = 7,
    parameter int unsigned OPC_W         = 4,
    parameter int unsigned STACK_DEPTH   = 4,
    parameter int unsigned FETCH_ADDR    = 0,
    parameter int unsigned INDIRECT_ADDR = 5,
    parameter int unsigned NOP_ADDR      = 'h20
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpu_start,
    input  logic [2:0]        i_seq_op,
    input  logic [ADDR_W-1:0] i_branch_addr,
    input  logic [1:0]        i_cond_sel,
    input  logic              i_cond_inv,
    input  logic              i_flag_zf,
    input  logic              i_flag_nf,
    input  logic              i_flag_mf,
    input  logic              i_ir_valid,
    input  logic [OPC_W-1:0]  i_ir_opc,
    input  logic              i_ir_indirect,
    input  logic              i_halt,
    input  logic              i_step,
    input  logic              i_next_stim,
    input  logic              i_resume,
    input  logic              i_map_we,
    input  logic [OPC_W-1:0]  i_map_opc,
    input  logic [ADDR_W-1:0] i_map_addr,
    input  logic              i_clr_err,
    output logic [ADDR_W-1:0] o_car_addr,
    output logic [1:0]        o_state,
    output logic              o_stack_err,
    output logic              o_illegal
);

    localparam int unsigned MAP_N = 1 << OPC_W;
    // Stack pointer counts 0..STACK_DEPTH, so it needs one more code than the index.
    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [ADDR_W-1:0] FetchA    = ADDR_W'(FETCH_ADDR);
    localparam logic [ADDR_W-1:0] IndirectA = ADDR_W'(INDIRECT_ADDR);
    localparam logic [ADDR_W-1:0] NopA      = ADDR_W'(NOP_ADDR);
    localparam logic [SP_W-1:0]   SpFull    = SP_W'(STACK_DEPTH);

    typedef enum logic [1:0] {
        StRun  = 2'd0,
        StWait = 2'd1,
        StHalt = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OpHold     = 3'b000,
        OpInc      = 3'b001,
        OpDispatch = 3'b010,
        OpRetf     = 3'b011,
        OpBranch   = 3'b100,
        OpCall     = 3'b101,
        OpRet      = 3'b110,
        OpRsvd     = 3'b111
    } seq_op_e;

    state_e              state_q, state_d;
    seq_op_e             op;
    logic [ADDR_W-1:0]   car_q, car_d;
    logic [ADDR_W-1:0]   car_inc;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic [SP_W-1:0]     sp_inc, sp_dec;
    logic [IDX_W-1:0]    push_idx, pop_idx;
    logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0]   map_q [MAP_N];
    logic [MAP_N-1:0]    map_vld_q;
    logic [OPC_W-1:0]    opc_q;
    logic                ind_q;
    logic                ind_done_q, ind_done_d;
    logic                err_q, err_d;
    logic                illegal_q, illegal_d;
    logic                push;
    logic                err_set;
    logic                stack_full, stack_empty;
    logic                flag_sel, cond_met;

    assign op          = seq_op_e'(i_seq_op);
    assign car_inc     = car_q + ADDR_W'(1);
    assign sp_inc      = sp_q + SP_W'(1);
    assign sp_dec      = sp_q - SP_W'(1);
    assign push_idx    = sp_q[IDX_W-1:0];
    assign pop_idx     = sp_dec[IDX_W-1:0];
    assign stack_full  = (sp_q == SpFull);
    assign stack_empty = (sp_q == '0);

    // Branch condition: selected ALU flag, optionally inverted.
    always_comb begin
        flag_sel = 1'b1;
        case (i_cond_sel)
            2'd0:    flag_sel = 1'b1;
            2'd1:    flag_sel = i_flag_zf;
            2'd2:    flag_sel = i_flag_nf;
            default: flag_sel = i_flag_mf;
        endcase
    end

    assign cond_met = flag_sel ^ i_cond_inv;

    // Next-state / next-address logic; everything holds while the CPU is stopped.
    always_comb begin
        state_d    = state_q;
        car_d      = car_q;
        sp_d       = sp_q;
        ind_done_d = ind_done_q;
        push       = 1'b0;
        err_set    = 1'b0;
        illegal_d  = 1'b0;

        if (i_cpu_start) begin
            unique case (state_q)
                StRun: begin
                    case (op)
                        OpInc: car_d = car_inc;
                        OpDispatch: begin
                            // Indirect instructions detour once through the indirect routine.
                            if (ind_q && !ind_done_q) begin
                                car_d      = IndirectA;
                                ind_done_d = 1'b1;
                            end else if (map_vld_q[opc_q]) begin
                                car_d = map_q[opc_q];
                            end else begin
                                car_d     = FetchA;
                                illegal_d = 1'b1;
                            end
                        end
                        OpRetf: begin
                            if (i_halt) begin
                                state_d = StHalt;
                            end else if (i_step && !i_next_stim) begin
                                state_d = StWait;
                                car_d   = NopA;
                            end else begin
                                car_d      = FetchA;
                                ind_done_d = 1'b0;
                            end
                        end
                        OpBranch: car_d = cond_met ? i_branch_addr : car_inc;
                        OpCall: begin
                            if (!stack_full) begin
                                push  = 1'b1;
                                sp_d  = sp_inc;
                                car_d = i_branch_addr;
                            end else begin
                                err_set = 1'b1;
                            end
                        end
                        OpRet: begin
                            if (!stack_empty) begin
                                car_d = stack_q[pop_idx];
                                sp_d  = sp_dec;
                            end else begin
                                car_d   = FetchA;
                                err_set = 1'b1;
                            end
                        end
                        default: car_d = car_q;
                    endcase
                end
                StWait: begin
                    // Stimulus takes precedence over a simultaneous halt request.
                    if (i_next_stim) begin
                        state_d    = StRun;
                        car_d      = FetchA;
                        ind_done_d = 1'b0;
                    end else if (i_halt) begin
                        state_d = StHalt;
                    end
                end
                StHalt: begin
                    if (i_resume) begin
                        state_d    = StRun;
                        car_d      = FetchA;
                        ind_done_d = 1'b0;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    // Sticky stack error: a new error wins over a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (err_set) begin
            err_d = 1'b1;
        end else if (i_clr_err) begin
            err_d = 1'b0;
        end
    end

    // Sequencer control registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StRun;
            car_q      <= FetchA;
            sp_q       <= '0;
            ind_done_q <= 1'b0;
            err_q      <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            car_q      <= car_d;
            sp_q       <= sp_d;
            ind_done_q <= ind_done_d;
            err_q      <= err_d;
            illegal_q  <= illegal_d;
        end
    end

    // Instruction register capture, independent of the sequencer state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            opc_q <= '0;
            ind_q <= 1'b0;
        end else if (i_ir_valid) begin
            opc_q <= i_ir_opc;
            ind_q <= i_ir_indirect;
        end
    end

    // Return stack storage; the pushed value is the address after the CALL.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                stack_q[i] <= '0;
            end
        end else if (push) begin
            stack_q[push_idx] <= car_inc;
        end
    end

    // Dispatch map; the DISPATCH read above sees the pre-write entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(MAP_N); i++) begin
                map_q[i] <= '0;
            end
            map_vld_q <= '0;
        end else if (i_map_we) begin
            map_q[i_map_opc]     <= i_map_addr;
            map_vld_q[i_map_opc] <= 1'b1;
        end
    end

    assign o_car_addr  = i_cpu_start ? car_q : NopA;
    assign o_state     = state_q;
    assign o_stack_err = err_q;
    assign o_illegal   = illegal_q;

endmodule

// File: tb/tb_cu_microsequencer.sv
// Self-checking bench for cu_microsequencer: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model (queue-based return stack, array dispatch map).
`timescale 1ns/1ps
module tb_cu_microsequencer;

    localparam int AW    = 7;
    localparam int DEPTH = 4;
    localparam int FETCH = 0;
    localparam int INDIR = 5;
    localparam int NOP   = 'h20;

    localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, DISP = 3'd2, RETF = 3'd3;
    localparam logic [2:0] BRAN = 3'd4, CALL = 3'd5, RET = 3'd6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_start, cond_inv, zf, nf, mf, ir_valid, ir_indirect;
    logic       halt, step, next_stim, resume, map_we, clr_err;
    logic [2:0] seq_op;
    logic [6:0] branch_addr, map_addr, car_addr;
    logic [1:0] cond_sel, state;
    logic [3:0] ir_opc, map_opc;
    logic       stack_err, illegal;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // Behavioural model state.
    int m_car, m_state, m_opc;
    int m_stack[$];
    int m_map[16];
    bit m_vld[16];
    bit m_ind, m_done, m_err, m_ill;
    bit new_err, new_ill;

    always #5 clk = ~clk;

    cu_microsequencer dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_cpu_start   (cpu_start),
        .i_seq_op      (seq_op),
        .i_branch_addr (branch_addr),
        .i_cond_sel    (cond_sel),
        .i_cond_inv    (cond_inv),
        .i_flag_zf     (zf),
        .i_flag_nf     (nf),
        .i_flag_mf     (mf),
        .i_ir_valid    (ir_valid),
        .i_ir_opc      (ir_opc),
        .i_ir_indirect (ir_indirect),
        .i_halt        (halt),
        .i_step        (step),
        .i_next_stim   (next_stim),
        .i_resume      (resume),
        .i_map_we      (map_we),
        .i_map_opc     (map_opc),
        .i_map_addr    (map_addr),
        .i_clr_err     (clr_err),
        .o_car_addr    (car_addr),
        .o_state       (state),
        .o_stack_err   (stack_err),
        .o_illegal     (illegal)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_car   = FETCH;
        m_state = 0;
        m_opc   = 0;
        m_ind   = 1'b0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_ill   = 1'b0;
        m_stack.delete();
        for (int i = 0; i < 16; i++) begin
            m_map[i] = 0;
            m_vld[i] = 1'b0;
        end
    endtask

    function automatic bit cond_true();
        bit f;
        case (cond_sel)
            2'd0:    f = 1'b1;
            2'd1:    f = zf;
            2'd2:    f = nf;
            default: f = mf;
        endcase
        return f ^ cond_inv;
    endfunction

    // One clock edge of the sequencer's architectural behaviour.
    task automatic m_step();
        new_err = 1'b0;
        new_ill = 1'b0;
        if (cpu_start) begin
            if (m_state == 0) begin
                case (seq_op)
                    INC:  m_car = (m_car + 1) % 128;
                    DISP: begin
                        if (m_ind && !m_done) begin
                            m_car  = INDIR;
                            m_done = 1'b1;
                        end else if (m_vld[m_opc]) begin
                            m_car = m_map[m_opc];
                        end else begin
                            m_car   = FETCH;
                            new_ill = 1'b1;
                        end
                    end
                    RETF: begin
                        if (halt) m_state = 2;
                        else if (step && !next_stim) begin
                            m_state = 1;
                            m_car   = NOP;
                        end else begin
                            m_car  = FETCH;
                            m_done = 1'b0;
                        end
                    end
                    BRAN: m_car = cond_true() ? int'(branch_addr) : (m_car + 1) % 128;
                    CALL: begin
                        if (m_stack.size() < DEPTH) begin
                            m_stack.push_back((m_car + 1) % 128);
                            m_car = branch_addr;
                        end else begin
                            new_err = 1'b1;
                        end
                    end
                    RET: begin
                        if (m_stack.size() > 0) m_car = m_stack.pop_back();
                        else begin
                            m_car   = FETCH;
                            new_err = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (m_state == 1) begin
                if (next_stim) begin
                    m_state = 0;
                    m_car   = FETCH;
                    m_done  = 1'b0;
                end else if (halt) begin
                    m_state = 2;
                end
            end else if (resume) begin
                m_state = 0;
                m_car   = FETCH;
                m_done  = 1'b0;
            end
        end
        if (map_we) begin
            m_map[map_opc] = map_addr;
            m_vld[map_opc] = 1'b1;
        end
        if (ir_valid) begin
            m_opc = ir_opc;
            m_ind = ir_indirect;
        end
        m_ill = new_ill;
        if (new_err) m_err = 1'b1;
        else if (clr_err) m_err = 1'b0;
    endtask

    // Model process: follows the clock edge and the asynchronous reset.
    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    // Compare process: every output, every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("car", car_addr, cpu_start ? m_car : NOP);
                check("state", state, m_state);
                check("stack_err", stack_err, m_err);
                check("illegal", illegal, m_ill);
            end
        end
    end

    task automatic quiet();
        cpu_start = 1'b1; seq_op = HOLD; branch_addr = '0; cond_sel = '0; cond_inv = 1'b0;
        zf = 1'b0; nf = 1'b0; mf = 1'b0; ir_valid = 1'b0; ir_opc = '0; ir_indirect = 1'b0;
        halt = 1'b0; step = 1'b0; next_stim = 1'b0; resume = 1'b0; map_we = 1'b0;
        map_opc = '0; map_addr = '0; clr_err = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [6:0] a);
        quiet();
        seq_op      = o;
        branch_addr = a;
        tick();
    endtask

    task automatic branch(input logic [1:0] sel, input logic inv, input logic z,
                          input logic [6:0] a);
        quiet();
        seq_op = BRAN; cond_sel = sel; cond_inv = inv; zf = z; branch_addr = a;
        tick();
    endtask

    initial begin
        int ret_exp [4];
        ret_exp = '{'h61, 'h51, 'h31, 'h11};
        quiet();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_car", car_addr, 0);
        check("rst_state", state, 0);
        check("rst_err", stack_err, 0);
        check("rst_illegal", illegal, 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Dispatch with indirect detour
        quiet();
        map_we = 1'b1; map_opc = 4'd3; map_addr = 7'h0B;
        ir_valid = 1'b1; ir_opc = 4'd3; ir_indirect = 1'b1;
        tick();
        run_op(DISP, 0); check("disp_indirect", car_addr, 'h05);
        run_op(DISP, 0); check("disp_map", car_addr, 'h0B);
        run_op(RETF, 0); check("retf_fetch", car_addr, 'h00);
        run_op(DISP, 0); check("disp_indirect_again", car_addr, 'h05);

        // Unmapped opcode
        quiet(); ir_valid = 1'b1; ir_opc = 4'd9; tick();
        run_op(DISP, 0);
        check("illegal_car", car_addr, 'h00);
        check("illegal_pulse", illegal, 1);
        run_op(HOLD, 0); check("illegal_one_cycle", illegal, 0);

        // Conditional branch
        branch(2'd0, 1'b0, 1'b0, 7'h10); check("br_always", car_addr, 'h10);
        branch(2'd1, 1'b0, 1'b1, 7'h40); check("br_zf1", car_addr, 'h40);
        branch(2'd0, 1'b0, 1'b0, 7'h10);
        branch(2'd1, 1'b0, 1'b0, 7'h40); check("br_zf0", car_addr, 'h11);
        branch(2'd0, 1'b0, 1'b0, 7'h10);
        branch(2'd1, 1'b1, 1'b1, 7'h40); check("br_inv_zf1", car_addr, 'h11);
        branch(2'd0, 1'b0, 1'b0, 7'h10);
        branch(2'd1, 1'b1, 1'b0, 7'h40); check("br_inv_zf0", car_addr, 'h40);

        // Call stack fill, overflow, unwind, underflow
        branch(2'd0, 1'b0, 1'b0, 7'h10);
        run_op(CALL, 7'h30); check("call1", car_addr, 'h30);
        run_op(CALL, 7'h50); check("call2", car_addr, 'h50);
        run_op(CALL, 7'h60); check("call3", car_addr, 'h60);
        run_op(CALL, 7'h70); check("call4", car_addr, 'h70);
        check("no_err_yet", stack_err, 0);
        run_op(CALL, 7'h7F); check("overflow_car", car_addr, 'h70);
        check("overflow_err", stack_err, 1);
        for (int i = 0; i < 4; i++) begin
            run_op(RET, 0);
            check("ret_addr", car_addr, ret_exp[i]);
        end
        run_op(RET, 0); check("underflow_car", car_addr, 'h00);
        check("underflow_err", stack_err, 1);
        quiet(); clr_err = 1'b1; tick();
        check("clr_err", stack_err, 0);

        // Step-execution wait
        quiet(); seq_op = RETF; step = 1'b1; tick();
        check("wait_state", state, 1);
        check("wait_car", car_addr, 'h20);
        for (int i = 0; i < 10; i++) begin
            quiet(); step = 1'b1; seq_op = 3'($urandom); branch_addr = 7'($urandom);
            tick();
            check("wait_hold_car", car_addr, 'h20);
            check("wait_hold_state", state, 1);
        end
        quiet(); next_stim = 1'b1; tick();
        check("stim_car", car_addr, 'h00);
        check("stim_state", state, 0);

        // Halt / resume
        run_op(INC, 0);
        quiet(); seq_op = RETF; halt = 1'b1; tick();
        check("halt_state", state, 2);
        for (int i = 0; i < 5; i++) begin
            quiet(); seq_op = 3'($urandom); branch_addr = 7'($urandom); tick();
            check("halt_car", car_addr, 'h01);
        end
        quiet(); resume = 1'b1; tick();
        check("resume_car", car_addr, 'h00);
        check("resume_state", state, 0);

        // CPU stopped
        run_op(INC, 0);
        run_op(INC, 0);
        for (int i = 0; i < 3; i++) begin
            quiet(); cpu_start = 1'b0; seq_op = INC; tick();
            check("stopped_nop", car_addr, 'h20);
        end
        quiet();
        #1;
        check("stopped_car_kept", car_addr, 'h02);
        tick();

        // Randomized traffic with occasional asynchronous reset
        for (int k = 0; k < 3000; k++) begin
            quiet();
            cpu_start   = ($urandom_range(0, 9) != 0);
            seq_op      = 3'($urandom);
            branch_addr = 7'($urandom);
            cond_sel    = 2'($urandom);
            cond_inv    = 1'($urandom);
            zf          = 1'($urandom);
            nf          = 1'($urandom);
            mf          = 1'($urandom);
            ir_valid    = cpu_start && ($urandom_range(0, 4) == 0);
            ir_opc      = 4'($urandom);
            ir_indirect = ($urandom_range(0, 3) == 0);
            step        = ($urandom_range(0, 3) == 0);
            next_stim   = ($urandom_range(0, 2) == 0);
            halt        = !next_stim && ($urandom_range(0, 7) == 0);
            resume      = ($urandom_range(0, 3) == 0);
            map_we      = ($urandom_range(0, 5) == 0);
            map_opc     = 4'($urandom);
            map_addr    = 7'($urandom);
            clr_err     = cpu_start && ($urandom_range(0, 15) == 0);
            if (k % 700 == 350) begin
                #1 rst_n = 1'b0;
                #1;
                check("async_rst_car", car_addr, cpu_start ? 0 : 'h20);
                check("async_rst_state", state, 0);
                @(posedge clk);
                #2 rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
